obstacle_placer: RTL
====================

// Module: obstacle_placer
// PURPOSE
//  Consumer end of the obstacle random-coordinate generator.
//  - Samples candidate cells (randX/randY) and validates each one against bounds, snake occupancy and stored obstacles.
//  - Commits valid cells into an obstacle table.
//  - Pulses obstacleFlag to advance the generator after every accepted or rejected candidate.
//  - Serves a combinational "obstacle at (px,py)" lookup for the renderer and collision logic.
// PARAMETERS
//  MAX_OBS    8   obstacle table depth (1..15)
//  MAX_RETRY  15  rejected candidates allowed before place_fail (1..15)
// PORTS
//  clk           in   1  clock
//  nRst          in   1  reset, asynchronous, active-low
//  clear         in   1  sync clear: empty table, abort placement
//  place_req     in   1  request one placement; sampled only in IDLE
//  randX, randY  in   4  candidate from generator
//  randX2,randY2 in   4  second candidate (used only with OBSTACLE_PAIR_EN)
//  occ_x, occ_y  out  4  cell presented to snake-body occupancy check
//  occ_hit       in   1  combinational reply: occ cell holds snake
//  obstacleFlag  out  1  one-cycle pulse: generator advances
//  place_done    out  1  one-cycle pulse: obstacle(s) committed
//  place_fail    out  1  one-cycle pulse: table full or retries exhausted
//  busy          out  1  FSM not in IDLE
//  obs_count     out  4  valid entries in table
//  px, py        in   4  lookup cell
//  obs_at_p      out  1  combinational: (px,py) matches a valid entry
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, table entries invalid, retry=0, occ_x/occ_y=0.
//  Grid: legal cell x in 1..14, y in 1..10.
//  States and transitions:
//  - IDLE: on place_req,
//    - obs_count==MAX_OBS -> place_fail next cycle, no obstacleFlag, stay IDLE;
//    - else -> SAMPLE, retry=0.
//  - SAMPLE: latch cand=(randX,randY) -> CHECK.
//  - CHECK: drive occ_x/occ_y=cand. Candidate is rejected if any of:
//    - occ_hit is 1;
//    - cand is out of grid;
//    - cand equals a valid table entry.
//    Reject -> RETRY; accept -> COMMIT.
//  - RETRY: obstacleFlag=1, retry++.
//    - retry reaches MAX_RETRY -> place_fail, IDLE;
//    - else -> SAMPLE.
//  - COMMIT: write cand to lowest invalid slot, obs_count++, obstacleFlag=1, place_done=1 -> IDLE.
//  Latency: best case place_req -> place_done is 3 cycles (SAMPLE, CHECK, COMMIT). Each reject adds 3 cycles.
//  Arithmetic: all compares are on 4-bit unsigned values; retry counter saturates and never wraps.
//  Simultaneous events and boundaries:
//  - clear has priority over everything: table invalidated, obs_count=0, FSM=IDLE, no pulses that cycle.
//  - place_req while busy is ignored (not queued).
//  - place_req and clear in the same cycle: clear wins, request dropped.
//  - Table never overflows; full is reported only via place_fail.
//  - obs_at_p reflects a committed entry from the cycle after COMMIT.
//  - Async reset mid-placement: immediate return to reset state.
// CONFIGURATION
//  OBSTACLE_PAIR_EN defined:
//  - SAMPLE also latches cand2=(randX2,randY2).
//  - Added state CHECK2 follows an accepted CHECK and drives occ_x/occ_y=cand2. cand2 is rejected if:
//    - occ_hit is 1;
//    - cand2 lies outside x 3..12, y 3..8;
//    - cand2 equals cand or a table entry.
//  - Requires obs_count<=MAX_OBS-2, else place_fail from IDLE.
//  - Both cells commit in one COMMIT, obs_count+=2, single place_done.
//  - Rejecting either cell rejects the pair and goes to RETRY.
//  OBSTACLE_PAIR_EN undefined:
//  - randX2/randY2 are ignored and CHECK2 does not exist.
//  - Single-cell placement as described above.
// STRUCTURE
//  Package obstacle_pkg:
//  - typedef logic [3:0] coord_t;
//  - GRID_X_MIN=1, GRID_X_MAX=14, GRID_Y_MIN=1, GRID_Y_MAX=10;
//  - PAIR_X_MIN=3, PAIR_X_MAX=12, PAIR_Y_MIN=3, PAIR_Y_MAX=8;
//  - enum placer_state_t {IDLE,SAMPLE,CHECK,CHECK2,RETRY,COMMIT}.
//  Sub-module obstacle_store:
//  - MAX_OBS entries of valid/x/y with write port and clear;
//  - two match ports: one for the candidate duplicate check, one for the px/py lookup;
//  - provides lowest-free-slot index and count.
//  Top level: FSM, candidate registers, retry counter.
// TESTING
//  1 reset, then place_req with rand=(5,3), occ_hit=0 -> place_done 3 cycles later, obs_count=1, one obstacleFlag pulse; px,py=(5,3) -> obs_at_p=1.
//  2 occ_hit=1 on first candidate (5,3), next (6,4) free -> exactly 2 obstacleFlag pulses, table holds (6,4) only.
//  3 candidate duplicates a stored (6,4) every attempt -> 15 obstacleFlag pulses, then place_fail, obs_count unchanged.
//  4 fill to MAX_OBS=8, then place_req -> place_fail next cycle, no obstacleFlag, busy stays 0.
//  5 clear asserted during CHECK -> next cycle IDLE, obs_count=0, obs_at_p=0 everywhere, no done/fail pulse.
//  6 with OBSTACLE_PAIR_EN: rand=(8,3), rand2=(3,5) -> both committed, obs_count+=2; rand2=(13,5) -> pair rejected, retry.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared types, grid limits and FSM state encoding for the obstacle placer.
// Optional pair placement is selected with the OBSTACLE_PAIR_EN macro.
package obstacle_pkg;

  typedef logic [3:0] coord_t;

  localparam coord_t GRID_X_MIN = 4'd1;
  localparam coord_t GRID_X_MAX = 4'd14;
  localparam coord_t GRID_Y_MIN = 4'd1;
  localparam coord_t GRID_Y_MAX = 4'd10;

  localparam coord_t PAIR_X_MIN = 4'd3;
  localparam coord_t PAIR_X_MAX = 4'd12;
  localparam coord_t PAIR_Y_MIN = 4'd3;
  localparam coord_t PAIR_Y_MAX = 4'd8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    CHECK  = 3'd2,
    CHECK2 = 3'd3,
    RETRY  = 3'd4,
    COMMIT = 3'd5
  } placer_state_t;

  function automatic logic in_box(input coord_t x, input coord_t y,
                                  input coord_t x_lo, input coord_t x_hi,
                                  input coord_t y_lo, input coord_t y_hi);
    return (x >= x_lo) && (x <= x_hi) && (y >= y_lo) && (y <= y_hi);
  endfunction

endpackage

// File: rtl/obstacle_placer_if.sv
// Signal bundle between the obstacle placer and its environment (generator,
// snake occupancy, renderer). Pair placement uses randX2/randY2 under OBSTACLE_PAIR_EN.
interface obstacle_placer_if;
  import obstacle_pkg::*;

  // Handshake: place_req is a request accepted only while busy is low (it is
  // never queued); each accepted request ends in exactly one single-cycle
  // place_done or place_fail. obstacleFlag pulses once per judged candidate.
  logic          clear;
  logic          place_req;
  coord_t        randX, randY;
  coord_t        randX2, randY2;
  coord_t        occ_x, occ_y;
  logic          occ_hit;
  logic          obstacleFlag;
  logic          place_done;
  logic          place_fail;
  logic          busy;
  logic [3:0]    obs_count;
  coord_t        px, py;
  logic          obs_at_p;
  placer_state_t state_dbg;

  modport master (
    output clear, place_req, randX, randY, randX2, randY2, occ_hit, px, py,
    input  occ_x, occ_y, obstacleFlag, place_done, place_fail, busy,
           obs_count, obs_at_p, state_dbg
  );

  modport slave (
    input  clear, place_req, randX, randY, randX2, randY2, occ_hit, px, py,
    output occ_x, occ_y, obstacleFlag, place_done, place_fail, busy,
           obs_count, obs_at_p, state_dbg
  );

endinterface

// File: rtl/obstacle_store.sv
// Obstacle table: valid/x/y entries, lowest-free-slot allocation, entry count,
// a candidate duplicate match port and a renderer lookup match port.
module obstacle_store
  import obstacle_pkg::*;
#(
  parameter int MAX_OBS = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       clear,
  input  logic       wr_en,
  input  coord_t     wr_x,
  input  coord_t     wr_y,
  input  logic       wr2_en,
  input  coord_t     wr2_x,
  input  coord_t     wr2_y,
  input  coord_t     mx,
  input  coord_t     my,
  output logic       m_hit,
  input  coord_t     px,
  input  coord_t     py,
  output logic       p_hit,
  output logic [3:0] count
);

  logic [MAX_OBS-1:0] valid;
  coord_t             ex [MAX_OBS];
  coord_t             ey [MAX_OBS];
  logic [3:0]         free_idx, free2_idx;
  logic               found, found2;

  // Second write lands in the next free slot above the first one.
  always_comb begin
    free_idx  = '0;
    free2_idx = '0;
    found     = 1'b0;
    found2    = 1'b0;
    count     = '0;
    m_hit     = 1'b0;
    p_hit     = 1'b0;
    for (int i = 0; i < MAX_OBS; i++) begin
      count = count + {3'b000, valid[i]};
      if (valid[i] && ex[i] == mx && ey[i] == my) m_hit = 1'b1;
      if (valid[i] && ex[i] == px && ey[i] == py) p_hit = 1'b1;
      if (!valid[i]) begin
        if (!found) begin
          free_idx = 4'(i);
          found    = 1'b1;
        end else if (!found2) begin
          free2_idx = 4'(i);
          found2    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      valid <= '0;
      for (int i = 0; i < MAX_OBS; i++) begin
        ex[i] <= '0;
        ey[i] <= '0;
      end
    end else if (clear) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < MAX_OBS; i++) begin
        if (wr_en && found && 4'(i) == free_idx) begin
          valid[i] <= 1'b1;
          ex[i]    <= wr_x;
          ey[i]    <= wr_y;
        end else if (wr2_en && found2 && 4'(i) == free2_idx) begin
          valid[i] <= 1'b1;
          ex[i]    <= wr2_x;
          ey[i]    <= wr2_y;
        end
      end
    end
  end

endmodule

// File: rtl/obstacle_placer.sv
// Obstacle placer top: placement FSM, candidate registers and retry counter.
// Define OBSTACLE_PAIR_EN to place two validated cells per request.
module obstacle_placer
  import obstacle_pkg::*;
#(
  parameter int MAX_OBS   = 8,
  parameter int MAX_RETRY = 15
) (
  input logic          clk,
  input logic          nRst,
  obstacle_placer_if.slave bus
);

  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);
  localparam logic [3:0] RETRY_LAST = 4'(MAX_RETRY - 1);

  placer_state_t state_q, state_d;
  coord_t        cand_x, cand_y;
  coord_t        cand2_x, cand2_y;
  coord_t        m_x, m_y;
  logic [3:0]    retry_q;
  logic [3:0]    obs_count;
  logic          full, full_fail_q, m_hit, cand_bad, cand2_bad;
  logic          flag, done, fail, wr_en, wr2_en;

`ifdef OBSTACLE_PAIR_EN
  // A pair needs two free slots.
  assign full      = obs_count >= 4'(MAX_OBS - 1);
  assign m_x       = (state_q == CHECK2) ? cand2_x : cand_x;
  assign m_y       = (state_q == CHECK2) ? cand2_y : cand_y;
  assign cand2_bad = bus.occ_hit | m_hit | ((cand2_x == cand_x) && (cand2_y == cand_y)) |
                     !in_box(cand2_x, cand2_y, PAIR_X_MIN, PAIR_X_MAX, PAIR_Y_MIN, PAIR_Y_MAX);
  assign wr2_en    = wr_en;
`else
  logic unused_rand2;
  assign unused_rand2 = ^{bus.randX2, bus.randY2};
  assign full      = obs_count >= 4'(MAX_OBS);
  assign m_x       = cand_x;
  assign m_y       = cand_y;
  assign cand2_bad = 1'b0;
  assign wr2_en    = 1'b0;
`endif

  assign cand_bad = bus.occ_hit | m_hit |
                    !in_box(cand_x, cand_y, GRID_X_MIN, GRID_X_MAX, GRID_Y_MIN, GRID_Y_MAX);

  always_comb begin
    state_d   = state_q;
    bus.occ_x = '0;
    bus.occ_y = '0;
    flag      = 1'b0;
    done      = 1'b0;
    fail      = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE:   if (bus.place_req && !full) state_d = SAMPLE;
      SAMPLE: state_d = CHECK;
      CHECK: begin
        bus.occ_x = cand_x;
        bus.occ_y = cand_y;
`ifdef OBSTACLE_PAIR_EN
        state_d   = cand_bad ? RETRY : CHECK2;
`else
        state_d   = cand_bad ? RETRY : COMMIT;
`endif
      end
`ifdef OBSTACLE_PAIR_EN
      CHECK2: begin
        bus.occ_x = cand2_x;
        bus.occ_y = cand2_y;
        state_d   = cand2_bad ? RETRY : COMMIT;
      end
`endif
      RETRY: begin
        flag = 1'b1;
        if (retry_q >= RETRY_LAST) begin
          fail    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SAMPLE;
        end
      end
      COMMIT: begin
        flag    = 1'b1;
        done    = 1'b1;
        wr_en   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides everything, including pulses due this cycle.
    if (bus.clear) begin
      state_d = IDLE;
      flag    = 1'b0;
      done    = 1'b0;
      fail    = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      cand_x      <= '0;
      cand_y      <= '0;
      cand2_x     <= '0;
      cand2_y     <= '0;
      retry_q     <= '0;
      full_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_fail_q <= !bus.clear && (state_q == IDLE) && bus.place_req && full;
      if (state_q == SAMPLE) begin
        cand_x  <= bus.randX;
        cand_y  <= bus.randY;
        cand2_x <= bus.randX2;
        cand2_y <= bus.randY2;
      end
      if (bus.clear || (state_q == IDLE && bus.place_req)) retry_q <= '0;
      else if (state_q == RETRY && retry_q < RETRY_MAX) retry_q <= retry_q + 4'd1;
    end
  end

  obstacle_store #(.MAX_OBS(MAX_OBS)) u_store (
    .clk   (clk),
    .nRst  (nRst),
    .clear (bus.clear),
    .wr_en (wr_en),
    .wr_x  (cand_x),
    .wr_y  (cand_y),
    .wr2_en(wr2_en),
    .wr2_x (cand2_x),
    .wr2_y (cand2_y),
    .mx    (m_x),
    .my    (m_y),
    .m_hit (m_hit),
    .px    (bus.px),
    .py    (bus.py),
    .p_hit (bus.obs_at_p),
    .count (obs_count)
  );

  assign bus.obstacleFlag = flag;
  assign bus.place_done   = done;
  assign bus.place_fail   = fail | (full_fail_q & ~bus.clear);
  assign bus.busy         = (state_q != IDLE);
  assign bus.obs_count    = obs_count;
  assign bus.state_dbg    = state_q;

endmodule
